// File: rtl/bkm_iter_sequencer_if.sv
// Handshake bundle between the BKM iteration sequencer, the digit-selection
// stage and the LUT decoder. The slave modport is the sequencer's view.
interface bkm_seq_if #(
    parameter int unsigned LOG2N = 6
) ();
    logic             start;
    logic             abort;
    logic             cfg_mode;
    logic [1:0]       cfg_format;
    logic             dp_d_valid;
    logic [1:0]       dp_d_x_n;
    logic [1:0]       dp_d_y_n;
    logic [LOG2N-1:0] lut_n;
    logic             lut_mode;
    logic [1:0]       lut_format;
    logic [1:0]       lut_d_x_n;
    logic [1:0]       lut_d_y_n;
    logic             lut_req;
    logic             dp_upd;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, cfg_mode, cfg_format,
        output dp_d_valid, dp_d_x_n, dp_d_y_n,
        input  lut_n, lut_mode, lut_format, lut_d_x_n, lut_d_y_n,
        input  lut_req, dp_upd, busy, done
    );

    modport slave (
        input  start, abort, cfg_mode, cfg_format,
        input  dp_d_valid, dp_d_x_n, dp_d_y_n,
        output lut_n, lut_mode, lut_format, lut_d_x_n, lut_d_y_n,
        output lut_req, dp_upd, busy, done
    );
endinterface

// File: rtl/bkm_iter_sequencer.sv
// Steps one BKM evaluation through N_ITER iterations: captures each digit
// pair, presents it to the LUT decoder, waits out the decoder latency and
// then strobes the datapath update. All outputs come straight from flops.
module bkm_iter_sequencer #(
    parameter int unsigned LOG2N   = 6,
    parameter int unsigned N_ITER  = 64,
    parameter int unsigned LAT_LUT = 1
) (
    input  logic     clk,
    input  logic     arst,
    input  logic     srst,
    input  logic     enable,
    bkm_seq_if.slave bus
);

    localparam int unsigned CNT_W = 3;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DIGIT = 3'd1;
    localparam logic [2:0] S_LUT   = 3'd2;
    localparam logic [2:0] S_UPD   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [LOG2N-1:0] N_LAST   = LOG2N'(N_ITER - 1);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LAT_LUT);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [LOG2N-1:0] n_q,     n_d;
    logic             mode_q,  mode_d;
    logic [1:0]       fmt_q,   fmt_d;
    logic [1:0]       dx_q,    dx_d;
    logic [1:0]       dy_q,    dy_d;
    logic             req_q,   req_d;
    logic             upd_q,   upd_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    // Next-state and next-output decode; abort wins over every transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        mode_d  = mode_q;
        fmt_d   = fmt_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        req_d   = 1'b0;
        upd_d   = 1'b0;
        done_d  = 1'b0;

        if (bus.abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_d = S_DIGIT;
                        mode_d  = bus.cfg_mode;
                        fmt_d   = bus.cfg_format;
                        n_d     = '0;
                    end
                end
                S_DIGIT: begin
                    if (bus.dp_d_valid) begin
                        dx_d    = bus.dp_d_x_n;
                        dy_d    = bus.dp_d_y_n;
                        req_d   = 1'b1;
                        cnt_d   = LAT_LOAD;
                        state_d = S_LUT;
                    end
                end
                S_LUT: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_UPD;
                        upd_d   = 1'b1;
                    end
                end
                S_UPD: begin
                    if (n_q == N_LAST) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        n_d     = n_q + LOG2N'(1);
                        state_d = S_DIGIT;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    // State and output registers; enable freezes everything including srst.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            n_q     <= '0;
            mode_q  <= 1'b0;
            fmt_q   <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            req_q   <= 1'b0;
            upd_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (enable) begin
            if (srst) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                n_q     <= '0;
                mode_q  <= 1'b0;
                fmt_q   <= '0;
                dx_q    <= '0;
                dy_q    <= '0;
                req_q   <= 1'b0;
                upd_q   <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                n_q     <= n_d;
                mode_q  <= mode_d;
                fmt_q   <= fmt_d;
                dx_q    <= dx_d;
                dy_q    <= dy_d;
                req_q   <= req_d;
                upd_q   <= upd_d;
                busy_q  <= busy_d;
                done_q  <= done_d;
            end
        end
    end

    assign bus.lut_n      = n_q;
    assign bus.lut_mode   = mode_q;
    assign bus.lut_format = fmt_q;
    assign bus.lut_d_x_n  = dx_q;
    assign bus.lut_d_y_n  = dy_q;
    assign bus.lut_req    = req_q;
    assign bus.dp_upd     = upd_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_bkm_iter_sequencer.sv
// Scoreboard bench for bkm_iter_sequencer: dut 0 runs LAT_LUT=1, dut 1 runs
// LAT_LUT=3 with a 2-bit index. Stimulus queues expected pulses and snapshots;
// a negedge monitor matches them against what the duts present.
module tb_bkm_iter_sequencer;

    typedef struct {
        int         dut;
        int         kind;   // 0 lut_req, 1 dp_upd, 2 done
        int         cyc;
        int         n;
        logic [1:0] dx;
        logic [1:0] dy;
        logic       m;
        logic [1:0] f;
    } evt_t;

    typedef struct {
        int         dut;
        int         cyc;
        logic       busy;
        logic       done;
        logic       req;
        logic       upd;
        int         n;
        logic       m;
        logic [1:0] f;
    } snap_t;

    typedef struct {
        logic       busy;
        logic       done;
        logic       req;
        logic       upd;
        int         n;
        logic [1:0] dx;
        logic [1:0] dy;
        logic       m;
        logic [1:0] f;
    } obs_t;

    logic  clk    = 1'b0;
    logic  arst   = 1'b0;
    logic  srst   = 1'b0;
    logic  enable = 1'b1;
    int    cyc    = 0;
    int    errors = 0;
    int    checks = 0;
    logic  end_req  = 1'b0;
    logic  end_seen = 1'b0;
    evt_t  exp_q[$];
    snap_t snap_q[$];

    bkm_seq_if #(.LOG2N(6)) bus_a ();
    bkm_seq_if #(.LOG2N(2)) bus_b ();

    bkm_iter_sequencer #(.LOG2N(6), .N_ITER(4), .LAT_LUT(1)) u_dut_a (
        .clk    (clk),
        .arst   (arst),
        .srst   (srst),
        .enable (enable),
        .bus    (bus_a)
    );

    bkm_iter_sequencer #(.LOG2N(2), .N_ITER(4), .LAT_LUT(3)) u_dut_b (
        .clk    (clk),
        .arst   (arst),
        .srst   (srst),
        .enable (enable),
        .bus    (bus_b)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [1:0] fx(int k);
        return 2'(k);
    endfunction

    function automatic logic [1:0] fy(int k);
        return 2'(k * 3 + 1);
    endfunction

    function automatic obs_t get_obs(int d);
        obs_t o;
        if (d == 0) begin
            o.busy = bus_a.busy;      o.done = bus_a.done;
            o.req  = bus_a.lut_req;   o.upd  = bus_a.dp_upd;
            o.n    = int'(bus_a.lut_n);
            o.dx   = bus_a.lut_d_x_n; o.dy   = bus_a.lut_d_y_n;
            o.m    = bus_a.lut_mode;  o.f    = bus_a.lut_format;
        end else begin
            o.busy = bus_b.busy;      o.done = bus_b.done;
            o.req  = bus_b.lut_req;   o.upd  = bus_b.dp_upd;
            o.n    = int'(bus_b.lut_n);
            o.dx   = bus_b.lut_d_x_n; o.dy   = bus_b.lut_d_y_n;
            o.m    = bus_b.lut_mode;  o.f    = bus_b.lut_format;
        end
        return o;
    endfunction

    // Advance one cycle; digits change every cycle so capture timing is visible.
    task automatic tick();
        @(posedge clk);
        #1;
        bus_a.dp_d_x_n = fx(cyc);
        bus_a.dp_d_y_n = fy(cyc);
        bus_b.dp_d_x_n = fx(cyc);
        bus_b.dp_d_y_n = fy(cyc);
    endtask

    task automatic wait_cyc(int t);
        while (cyc < t) tick();
    endtask

    task automatic exp_ev(int d, int k, int t, int n, logic [1:0] dx, logic [1:0] dy,
                          logic m, logic [1:0] f);
        evt_t e;
        e.dut = d; e.kind = k; e.cyc = t; e.n = n;
        e.dx = dx; e.dy = dy; e.m = m; e.f = f;
        exp_q.push_back(e);
    endtask

    task automatic exp_iter(int d, int r, int lat, int n, logic [1:0] dx, logic [1:0] dy,
                            logic m, logic [1:0] f);
        exp_ev(d, 0, r, n, dx, dy, m, f);
        exp_ev(d, 1, r + lat, n, dx, dy, m, f);
    endtask

    task automatic exp_snap(int d, int t, logic busy, logic done, logic req, logic upd,
                            int n, logic m, logic [1:0] f);
        snap_t s;
        s.dut = d; s.cyc = t; s.busy = busy; s.done = done; s.req = req;
        s.upd = upd; s.n = n; s.m = m; s.f = f;
        snap_q.push_back(s);
    endtask

    task automatic init_bus();
        bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.cfg_mode = 1'b0;
        bus_a.cfg_format = 2'b00; bus_a.dp_d_valid = 1'b0;
        bus_a.dp_d_x_n = 2'b00; bus_a.dp_d_y_n = 2'b00;
        bus_b.start = 1'b0; bus_b.abort = 1'b0; bus_b.cfg_mode = 1'b0;
        bus_b.cfg_format = 2'b00; bus_b.dp_d_valid = 1'b0;
        bus_b.dp_d_x_n = 2'b00; bus_b.dp_d_y_n = 2'b00;
    endtask

    // Monitor: retire overdue expectations, compare snapshots, match pulses.
    always @(negedge clk) begin
        obs_t  o;
        snap_t s;
        evt_t  e;
        int    idx;
        logic  pulse;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL evt_missing dut=%0d kind=%0d n=%0d: not seen, required at cycle %0d (now %0d)",
                     e.dut, e.kind, e.n, e.cyc, cyc);
        end
        while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
            s = snap_q.pop_front();
            o = get_obs(s.dut);
            checks++;
            if (o.busy !== s.busy || o.done !== s.done || o.req !== s.req || o.upd !== s.upd ||
                o.n != s.n || o.m !== s.m || o.f !== s.f) begin
                errors++;
                $display("FAIL snap dut=%0d cyc=%0d got busy=%b done=%b req=%b upd=%b n=%0d mode=%b fmt=%0d required busy=%b done=%b req=%b upd=%b n=%0d mode=%b fmt=%0d",
                         s.dut, cyc, o.busy, o.done, o.req, o.upd, o.n, o.m, o.f,
                         s.busy, s.done, s.req, s.upd, s.n, s.m, s.f);
            end
        end
        for (int d = 0; d < 2; d++) begin
            o = get_obs(d);
            for (int k = 0; k < 3; k++) begin
                pulse = (k == 0) ? o.req : ((k == 1) ? o.upd : o.done);
                if (pulse === 1'b1) begin
                    idx = -1;
                    foreach (exp_q[j]) begin
                        if (idx < 0 && exp_q[j].dut == d && exp_q[j].kind == k && exp_q[j].cyc == cyc)
                            idx = j;
                    end
                    checks++;
                    if (idx < 0) begin
                        errors++;
                        $display("FAIL evt_unexpected dut=%0d kind=%0d cyc=%0d n=%0d: pulse seen, none required",
                                 d, k, cyc, o.n);
                    end else begin
                        e = exp_q[idx];
                        exp_q.delete(idx);
                        if (o.n != e.n || o.dx !== e.dx || o.dy !== e.dy || o.m !== e.m || o.f !== e.f) begin
                            errors++;
                            $display("FAIL evt_payload dut=%0d kind=%0d cyc=%0d got n=%0d dx=%b dy=%b mode=%b fmt=%0d required n=%0d dx=%b dy=%b mode=%b fmt=%0d",
                                     d, k, cyc, o.n, o.dx, o.dy, o.m, o.f, e.n, e.dx, e.dy, e.m, e.f);
                        end
                    end
                end
            end
        end
        if (end_req && !end_seen) begin
            end_seen <= 1'b1;
            checks++;
            if (exp_q.size() != 0 || snap_q.size() != 0) begin
                errors++;
                $display("FAIL drain: %0d events and %0d snapshots left, required 0 and 0",
                         exp_q.size(), snap_q.size());
            end
        end
    end

    // Directed stimulus.
    initial begin
        int c;
        int c2;
        init_bus();

        // Reset state.
        tick();
        exp_snap(0, cyc, 0, 0, 0, 0, 0, 0, 2'd0);
        exp_snap(1, cyc, 0, 0, 0, 0, 0, 0, 2'd0);
        arst = 1'b1;
        wait_cyc(3);

        // Full run, valid held high; extra starts while busy and in DONE.
        c = cyc;
        bus_a.cfg_mode = 1'b1; bus_a.cfg_format = 2'b10;
        bus_a.dp_d_valid = 1'b1; bus_a.start = 1'b1;
        for (int i = 0; i < 4; i++)
            exp_iter(0, c + 2 + 3 * i, 1, i, fx(c + 1 + 3 * i), fy(c + 1 + 3 * i), 1'b1, 2'b10);
        exp_ev(0, 2, c + 13, 3, fx(c + 10), fy(c + 10), 1'b1, 2'b10);
        exp_snap(0, c + 1,  1, 0, 0, 0, 0, 1'b1, 2'b10);
        exp_snap(0, c + 12, 1, 0, 0, 1, 3, 1'b1, 2'b10);
        exp_snap(0, c + 13, 0, 1, 0, 0, 3, 1'b1, 2'b10);
        exp_snap(0, c + 15, 0, 0, 0, 0, 3, 1'b1, 2'b10);
        tick();
        bus_a.start = 1'b0; bus_a.cfg_mode = 1'b0; bus_a.cfg_format = 2'b00;
        wait_cyc(c + 5);
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        wait_cyc(c + 13);
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        wait_cyc(c + 16);

        // Digit stall in iteration 2, resume with explicit digits.
        c = cyc;
        bus_a.cfg_mode = 1'b0; bus_a.cfg_format = 2'b01; bus_a.start = 1'b1;
        exp_iter(0, c + 2,  1, 0, fx(c + 1), fy(c + 1), 1'b0, 2'b01);
        exp_iter(0, c + 5,  1, 1, fx(c + 4), fy(c + 4), 1'b0, 2'b01);
        exp_iter(0, c + 13, 1, 2, 2'b01, 2'b11, 1'b0, 2'b01);
        exp_iter(0, c + 16, 1, 3, fx(c + 15), fy(c + 15), 1'b0, 2'b01);
        exp_ev(0, 2, c + 18, 3, fx(c + 15), fy(c + 15), 1'b0, 2'b01);
        exp_snap(0, c + 9,  1, 0, 0, 0, 2, 1'b0, 2'b01);
        exp_snap(0, c + 12, 1, 0, 0, 0, 2, 1'b0, 2'b01);
        tick();
        bus_a.start = 1'b0;
        wait_cyc(c + 6);
        bus_a.dp_d_valid = 1'b0;
        wait_cyc(c + 12);
        bus_a.dp_d_valid = 1'b1; bus_a.dp_d_x_n = 2'b01; bus_a.dp_d_y_n = 2'b11;
        wait_cyc(c + 20);

        // Abort during LUT of iteration 1, then a clean restart.
        c = cyc;
        bus_a.cfg_mode = 1'b1; bus_a.cfg_format = 2'b11; bus_a.start = 1'b1;
        exp_iter(0, c + 2, 1, 0, fx(c + 1), fy(c + 1), 1'b1, 2'b11);
        exp_ev(0, 0, c + 5, 1, fx(c + 4), fy(c + 4), 1'b1, 2'b11);
        exp_snap(0, c + 5, 1, 0, 1, 0, 1, 1'b1, 2'b11);
        exp_snap(0, c + 6, 0, 0, 0, 0, 1, 1'b1, 2'b11);
        exp_snap(0, c + 9, 0, 0, 0, 0, 1, 1'b1, 2'b11);
        tick();
        bus_a.start = 1'b0;
        wait_cyc(c + 5);
        bus_a.abort = 1'b1;
        tick();
        bus_a.abort = 1'b0;
        wait_cyc(c + 10);
        c2 = cyc;
        bus_a.cfg_mode = 1'b0; bus_a.cfg_format = 2'b00; bus_a.start = 1'b1;
        exp_snap(0, c2 + 1, 1, 0, 0, 0, 0, 1'b0, 2'b00);
        for (int i = 0; i < 4; i++)
            exp_iter(0, c2 + 2 + 3 * i, 1, i, fx(c2 + 1 + 3 * i), fy(c2 + 1 + 3 * i), 1'b0, 2'b00);
        exp_ev(0, 2, c2 + 13, 3, fx(c2 + 10), fy(c2 + 10), 1'b0, 2'b00);
        tick();
        bus_a.start = 1'b0;
        wait_cyc(c2 + 15);

        // LAT_LUT=3 reference run on dut 1.
        c = cyc;
        bus_b.cfg_mode = 1'b1; bus_b.cfg_format = 2'b10;
        bus_b.dp_d_valid = 1'b1; bus_b.start = 1'b1;
        for (int i = 0; i < 4; i++)
            exp_iter(1, c + 2 + 5 * i, 3, i, fx(c + 1 + 5 * i), fy(c + 1 + 5 * i), 1'b1, 2'b10);
        exp_ev(1, 2, c + 21, 3, fx(c + 16), fy(c + 16), 1'b1, 2'b10);
        tick();
        bus_b.start = 1'b0;
        wait_cyc(c + 23);

        // Same run with enable low for 3 cycles mid-LUT of iteration 0.
        c = cyc;
        bus_b.start = 1'b1;
        exp_iter(1, c + 2, 6, 0, fx(c + 1), fy(c + 1), 1'b1, 2'b10);
        for (int i = 1; i < 4; i++)
            exp_iter(1, c + 5 + 5 * i, 3, i, fx(c + 4 + 5 * i), fy(c + 4 + 5 * i), 1'b1, 2'b10);
        exp_ev(1, 2, c + 24, 3, fx(c + 19), fy(c + 19), 1'b1, 2'b10);
        exp_snap(1, c + 5, 1, 0, 0, 0, 0, 1'b1, 2'b10);
        tick();
        bus_b.start = 1'b0;
        wait_cyc(c + 3);
        enable = 1'b0;
        wait_cyc(c + 6);
        enable = 1'b1;
        wait_cyc(c + 26);

        // Asynchronous reset between edges.
        c = cyc;
        bus_a.cfg_mode = 1'b1; bus_a.cfg_format = 2'b11; bus_a.start = 1'b1;
        exp_iter(0, c + 2, 1, 0, fx(c + 1), fy(c + 1), 1'b1, 2'b11);
        exp_snap(0, c + 4, 0, 0, 0, 0, 0, 1'b0, 2'b00);
        exp_snap(0, c + 6, 0, 0, 0, 0, 0, 1'b0, 2'b00);
        tick();
        bus_a.start = 1'b0;
        wait_cyc(c + 4);
        #2;
        arst = 1'b0;
        tick();
        arst = 1'b1;
        wait_cyc(c + 8);

        // Synchronous reset together with abort and start.
        c = cyc;
        bus_a.start = 1'b1;
        exp_iter(0, c + 2, 1, 0, fx(c + 1), fy(c + 1), 1'b1, 2'b11);
        exp_snap(0, c + 4, 0, 0, 0, 0, 0, 1'b0, 2'b00);
        exp_snap(0, c + 5, 0, 0, 0, 0, 0, 1'b0, 2'b00);
        tick();
        bus_a.start = 1'b0;
        wait_cyc(c + 3);
        srst = 1'b1; bus_a.abort = 1'b1; bus_a.start = 1'b1;
        tick();
        srst = 1'b0; bus_a.abort = 1'b0; bus_a.start = 1'b0;
        wait_cyc(c + 8);

        end_req = 1'b1;
        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
